cordic_job_queue: RTL and testbench
===================================

// Module: cordic_job_queue
// PURPOSE
//  Upstream sequencer for the CORDIC Controller. Buffers up to p_JOB_DEPTH jobs (x,y,z,control)
//  from a valid/ready source and issues each to the Controller with a one-cycle Start.
//  Captures every completion (x,y,z results and the 32-bit control/flag word) into a result FIFO.
//  Owns the Controller reset and drives the Stop bit for software abort.
// PARAMETERS
//  p_WIDTH      32   data width of x/y/z
//  p_JOB_DEPTH  4    job FIFO entries (power of 2, >=2)
//  p_RES_DEPTH  4    result FIFO entries (power of 2, >=2)
//  p_TIMEOUT    64   watchdog limit in BUSY cycles (used only with CORDIC_JQ_TIMEOUT_EN)
// PORTS
//  clk                         in   1        clock
//  rst                         in   1        synchronous active-low reset (0 = reset)
//  jobValid/jobReady           in/out 1      job push handshake; transfer when both high
//  jobX, jobY, jobZ            in   p_WIDTH  job operands
//  jobControl                  in   16       Controller control bits [12:0]; bits [1:0] ignored
//  abort                       in   1        pulse: stop the in-flight job
//  resultValid/resultReady     out/in 1      result pop handshake
//  resultX, resultY, resultZ   out  p_WIDTH  head-of-FIFO results
//  resultFlags                 out  32       Controller control/flag word captured at completion
//  jobCount, resultCount       out  clog2(D)+1  FIFO occupancy
//  cordicRst                   out  1        active-high reset to Controller
//  controlRegisterInput        out  32       to Controller: {16'h0, ctrl[15:2], stop, start}
//  xInput, yInput, zInput      out  p_WIDTH  to Controller: head job operands
//  controlRegisterOutput       in   32       from Controller
//  xResult, yResult, zResult   in   p_WIDTH  from Controller
//  controlRegisterWriteEnable  in   1        from Controller
// BEHAVIOUR
//  Reset (rst=0 at posedge): FIFOs emptied, state IDLE, cordicRst=1, start/stop=0,
//   resultValid=0, jobReady=0, counts=0. cordicRst is a register: =1 while rst=0 and one
//   cycle after; Controller is therefore reset whenever this block is. Any in-flight job is lost.
//  jobReady = rst && !cordicRst && jobCount<p_JOB_DEPTH. resultValid = resultCount!=0.
//  FSM:
//   IDLE  : job FIFO non-empty -> START (start bit 1 next cycle).
//   START : start=1 for exactly one cycle; x/y/zInput = head job. -> ACK.
//   ACK   : wait writeEnable with controlRegisterOutput[16]==0 (acceptance); pop job -> BUSY.
//   BUSY  : wait writeEnable with controlRegisterOutput[16]==1 (Ready). -> CAPTURE.
//           abort seen in BUSY (or latched in ACK) sets stop=1, held until Ready write.
//   CAPTURE: if resultCount<p_RES_DEPTH push {xResult,yResult,zResult,controlRegisterOutput};
//           -> IDLE. Else stay (Controller holds results in its idle state) until space.
//  Job push and pop in same cycle: count unchanged. Result push and pop in same cycle: same.
//  Push when full / pop when empty: ignored, no pointer change. Pointers wrap mod depth.
//  Earliest issue: job accepted at cycle t -> start=1 at t+2. Back-to-back jobs: IDLE lasts 1 cycle.
//  Controller interrupt line is not consumed; status is carried by resultFlags bits 31:16.
//  Input error (flag 17): completion arrives via PRE_C->POST_C; handled identically.
// CONFIGURATION
//  CORDIC_JQ_TIMEOUT_EN defined: 8-bit-or-wider counter cleared on entering BUSY, counts in
//   BUSY; at p_TIMEOUT cycles stop=1 as if abort. If no Ready write within p_TIMEOUT further
//   cycles, pulse cordicRst one cycle, push result with flags = 32'hFFFF_0000 and x/y/z = 0,
//   pop nothing further, -> IDLE.
//  Undefined: no counter, no forced stop; BUSY waits indefinitely.
// TESTING
//  Reset: rst=0 3 cycles mid-BUSY -> cordicRst=1, counts 0, resultValid=0, jobReady=0 until +2.
//  Single job x=0x4000_0000,y=0,z=0,ctrl=0x1F2C -> one start pulse, resultFlags[16]=1,
//   resultFlags[26:22]=31, resultCount=1.
//  Push 5 jobs with p_JOB_DEPTH=4, resultReady=0 -> jobReady low after 4th; 4 results then
//   stall in CAPTURE; pop one -> 5th completes, resultCount=4.
//  Hyperbolic ctrl=0x1F20, x=0x1000_0000,y=0x2000_0000 -> resultFlags[17]=1, no start re-issue.
//  abort 3 cycles after ACK with ctrl=0x1F2C -> stop=1, flags[26:22]<31, stop clears after capture.
//  Timeout (CORDIC_JQ_TIMEOUT_EN, p_TIMEOUT=8, Controller model never sets Ready) ->
//   flags=0xFFFF_0000 result pushed, cordicRst pulse.

Source files
------------

// File: rtl/cordic_job_queue.sv
// cordic_job_queue: buffers CORDIC jobs, issues each to the Controller with a Start pulse, queues results.
// Latency: a job accepted at cycle t raises Start at t+2; its result is pushed the cycle after CAPTURE.
// Backpressure: jobReady drops on a full job FIFO; a full result FIFO holds CAPTURE. Watchdog: CORDIC_JQ_TIMEOUT_EN.

module jq_fifo #(
   parameter int p_W     = 8,
   parameter int p_DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [p_W-1:0]           pushData,
   input  logic                     pop,
   output logic [p_W-1:0]           headData,
   output logic [$clog2(p_DEPTH):0] count
);
   localparam int AW = $clog2(p_DEPTH);

   logic [p_W-1:0] mem [p_DEPTH];
   logic [AW-1:0]  wrPtr;
   logic [AW-1:0]  rdPtr;
   logic           doPush;
   logic           doPop;

   assign doPush   = push && (count != (AW+1)'(p_DEPTH));
   assign doPop    = pop && (count != '0);
   assign headData = mem[rdPtr];

   always_ff @(posedge clk) begin
      if (!rst) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (doPush) wrPtr <= wrPtr + AW'(1);
         if (doPop)  rdPtr <= rdPtr + AW'(1);
         count <= count + (AW+1)'(doPush) - (AW+1)'(doPop);
      end
   end

   always_ff @(posedge clk) begin
      if (doPush) mem[wrPtr] <= pushData;
   end
endmodule

module cordic_job_queue #(
   parameter int p_WIDTH     = 32,
   parameter int p_JOB_DEPTH = 4,
   parameter int p_RES_DEPTH = 4,
   parameter int p_TIMEOUT   = 64
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         jobValid,
   output logic                         jobReady,
   input  logic [p_WIDTH-1:0]           jobX,
   input  logic [p_WIDTH-1:0]           jobY,
   input  logic [p_WIDTH-1:0]           jobZ,
   input  logic [15:0]                  jobControl,
   input  logic                         abort,
   output logic                         resultValid,
   input  logic                         resultReady,
   output logic [p_WIDTH-1:0]           resultX,
   output logic [p_WIDTH-1:0]           resultY,
   output logic [p_WIDTH-1:0]           resultZ,
   output logic [31:0]                  resultFlags,
   output logic [$clog2(p_JOB_DEPTH):0] jobCount,
   output logic [$clog2(p_RES_DEPTH):0] resultCount,
   output logic                         cordicRst,
   output logic [31:0]                  controlRegisterInput,
   output logic [p_WIDTH-1:0]           xInput,
   output logic [p_WIDTH-1:0]           yInput,
   output logic [p_WIDTH-1:0]           zInput,
   input  logic [31:0]                  controlRegisterOutput,
   input  logic [p_WIDTH-1:0]           xResult,
   input  logic [p_WIDTH-1:0]           yResult,
   input  logic [p_WIDTH-1:0]           zResult,
   input  logic                         controlRegisterWriteEnable
);
   localparam int JCW = $clog2(p_JOB_DEPTH) + 1;
   localparam int RCW = $clog2(p_RES_DEPTH) + 1;

   typedef struct packed {
      logic [p_WIDTH-1:0] x;
      logic [p_WIDTH-1:0] y;
      logic [p_WIDTH-1:0] z;
      logic [13:0]        ctrl;
   } jobWord_t;

   typedef struct packed {
      logic [p_WIDTH-1:0] x;
      logic [p_WIDTH-1:0] y;
      logic [p_WIDTH-1:0] z;
      logic [31:0]        flags;
   } resWord_t;

   typedef enum logic [2:0] {IDLE, START, ACK, BUSY, CAPTURE} state_t;

   state_t   state, nextState;
   jobWord_t jobIn, jobHead;
   resWord_t resIn, resHead;
   logic     jobPush, jobPop, resPush, resPop;
   logic     stop, abortLatched;
   logic     acceptWrite, readyWrite;
   logic     wdStop, wdExpire, timedOut;

   assign jobReady    = rst && !cordicRst && (jobCount < JCW'(p_JOB_DEPTH));
   assign jobPush     = jobValid && jobReady;
   assign resultValid = (resultCount != '0);
   assign resPop      = resultReady && resultValid;
   assign acceptWrite = controlRegisterWriteEnable && !controlRegisterOutput[16];
   assign readyWrite  = controlRegisterWriteEnable && controlRegisterOutput[16];

   assign jobIn = '{x: jobX, y: jobY, z: jobZ, ctrl: jobControl[15:2]};

   jq_fifo #(.p_W($bits(jobWord_t)), .p_DEPTH(p_JOB_DEPTH)) jobFifo (
      .clk(clk), .rst(rst), .push(jobPush), .pushData(jobIn),
      .pop(jobPop), .headData(jobHead), .count(jobCount)
   );

   // A watchdog-terminated job reports zero operands and an all-ones status half.
   always_comb begin
      resIn = '{x: xResult, y: yResult, z: zResult, flags: controlRegisterOutput};
      if (timedOut) resIn = '{x: '0, y: '0, z: '0, flags: 32'hFFFF_0000};
   end

   jq_fifo #(.p_W($bits(resWord_t)), .p_DEPTH(p_RES_DEPTH)) resFifo (
      .clk(clk), .rst(rst), .push(resPush), .pushData(resIn),
      .pop(resPop), .headData(resHead), .count(resultCount)
   );

   assign resultX     = resHead.x;
   assign resultY     = resHead.y;
   assign resultZ     = resHead.z;
   assign resultFlags = resHead.flags;

   assign xInput = jobHead.x;
   assign yInput = jobHead.y;
   assign zInput = jobHead.z;
   assign controlRegisterInput = {16'h0, jobHead.ctrl, stop, state == START};

   always_comb begin
      nextState = state;
      jobPop    = 1'b0;
      resPush   = 1'b0;
      case (state)
         IDLE:    if (jobCount != '0) nextState = START;
         START:   nextState = ACK;
         ACK:     if (acceptWrite) begin
                     jobPop    = 1'b1;
                     nextState = BUSY;
                  end
         BUSY:    if (readyWrite || wdExpire) nextState = CAPTURE;
         CAPTURE: if (resultCount < RCW'(p_RES_DEPTH)) begin
                     resPush   = 1'b1;
                     nextState = IDLE;
                  end
         default: nextState = IDLE;
      endcase
   end

   // Abort arriving before acceptance is held until the job is running.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state        <= IDLE;
         cordicRst    <= 1'b1;
         stop         <= 1'b0;
         abortLatched <= 1'b0;
      end else begin
         state     <= nextState;
         cordicRst <= wdExpire;
         if (state == ACK && abort) abortLatched <= 1'b1;
         if (state == BUSY) begin
            if (readyWrite || wdExpire) begin
               stop         <= 1'b0;
               abortLatched <= 1'b0;
            end else if (abort || abortLatched || wdStop) begin
               stop <= 1'b1;
            end
         end
      end
   end

`ifdef CORDIC_JQ_TIMEOUT_EN
   localparam int WDW = ($clog2(2*p_TIMEOUT) > 8) ? $clog2(2*p_TIMEOUT) : 8;
   logic [WDW-1:0] wdCnt;

   always_ff @(posedge clk) begin
      if (!rst) begin
         wdCnt    <= '0;
         timedOut <= 1'b0;
      end else begin
         wdCnt <= (state == BUSY) ? wdCnt + WDW'(1) : '0;
         if (wdExpire)     timedOut <= 1'b1;
         else if (resPush) timedOut <= 1'b0;
      end
   end

   assign wdStop   = (state == BUSY) && (wdCnt == WDW'(p_TIMEOUT-1));
   assign wdExpire = (state == BUSY) && !readyWrite && (wdCnt == WDW'(2*p_TIMEOUT-1));
`else
   assign wdStop   = 1'b0;
   assign wdExpire = 1'b0;
   assign timedOut = 1'b0;
`endif
endmodule

// File: tb/tb_cordic_job_queue.sv
// Directed bench for cordic_job_queue with a simple stand-in CORDIC Controller
// (iterates to 31 or until Stop; flags = {iter[26:22], err[17], ready[16], ctrl}).
module tb_cordic_job_queue;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        jobValid = 1'b0;
   logic        jobReady;
   logic [31:0] jobX = '0, jobY = '0, jobZ = '0;
   logic [15:0] jobControl = '0;
   logic        abort = 1'b0;
   logic        resultValid;
   logic        resultReady = 1'b0;
   logic [31:0] resultX, resultY, resultZ, resultFlags;
   logic [2:0]  jobCount, resultCount;
   logic        cordicRst;
   logic [31:0] controlRegisterInput;
   logic [31:0] xInput, yInput, zInput;
   logic [31:0] controlRegisterOutput = '0;
   logic [31:0] xResult = '0, yResult = '0, zResult = '0;
   logic        controlRegisterWriteEnable = 1'b0;

   logic pause = 1'b0;
   logic neverReady = 1'b0;
   int   nChecks = 0;
   int   nErrors = 0;
   int   startCount = 0;
   int   stopCycles = 0;
   int   rstPulses = 0;

   always #5 clk = ~clk;

   cordic_job_queue #(.p_WIDTH(32), .p_JOB_DEPTH(4), .p_RES_DEPTH(4), .p_TIMEOUT(8)) dut (
      .clk(clk), .rst(rst), .jobValid(jobValid), .jobReady(jobReady),
      .jobX(jobX), .jobY(jobY), .jobZ(jobZ), .jobControl(jobControl), .abort(abort),
      .resultValid(resultValid), .resultReady(resultReady),
      .resultX(resultX), .resultY(resultY), .resultZ(resultZ), .resultFlags(resultFlags),
      .jobCount(jobCount), .resultCount(resultCount), .cordicRst(cordicRst),
      .controlRegisterInput(controlRegisterInput), .xInput(xInput), .yInput(yInput), .zInput(zInput),
      .controlRegisterOutput(controlRegisterOutput), .xResult(xResult), .yResult(yResult),
      .zResult(zResult), .controlRegisterWriteEnable(controlRegisterWriteEnable)
   );

   typedef enum logic [1:0] {M_IDLE, M_ACCEPT, M_RUN, M_DONE} mState_t;
   mState_t     mState = M_IDLE;
   logic [31:0] mX = '0, mY = '0, mZ = '0;
   logic [15:0] mCtrl = '0;
   logic [4:0]  mIter = '0;
   logic        mErr = 1'b0;

   always @(posedge clk) begin
      if (cordicRst) begin
         mState <= M_IDLE;
         controlRegisterWriteEnable <= 1'b0;
         controlRegisterOutput <= '0;
         xResult <= '0; yResult <= '0; zResult <= '0;
         mIter <= '0; mErr <= 1'b0;
      end else begin
         case (mState)
            M_IDLE: if (controlRegisterInput[0]) begin
               mX <= xInput; mY <= yInput; mZ <= zInput;
               mCtrl <= {controlRegisterInput[15:2], 2'b00};
               mState <= M_ACCEPT;
            end
            M_ACCEPT: if (!pause) begin
               controlRegisterWriteEnable <= 1'b1;
               controlRegisterOutput <= {16'h0, mCtrl};
               mIter <= '0;
               mErr <= (mCtrl[3:2] == 2'b00) && (mY >= mX);
               mState <= M_RUN;
            end
            M_RUN: begin
               if (controlRegisterWriteEnable) controlRegisterWriteEnable <= 1'b0;
               else if (!neverReady && (mErr || controlRegisterInput[1] || mIter == 5'd31)) begin
                  controlRegisterWriteEnable <= 1'b1;
                  controlRegisterOutput <= {5'b0, mIter, 4'b0, mErr, 1'b1, mCtrl};
                  xResult <= mX + {27'b0, mIter};
                  yResult <= mY;
                  zResult <= mZ ^ {16'h0, mCtrl};
                  mState <= M_DONE;
               end else if (mIter != 5'd31) mIter <= mIter + 5'd1;
            end
            default: begin
               controlRegisterWriteEnable <= 1'b0;
               mState <= M_IDLE;
            end
         endcase
      end
   end

   always @(posedge clk) begin
      if (rst && controlRegisterInput[0]) startCount <= startCount + 1;
      if (rst && controlRegisterInput[1]) stopCycles <= stopCycles + 1;
      if (rst && cordicRst)               rstPulses  <= rstPulses + 1;
   end

   task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nChecks++;
      if (got !== exp) begin
         nErrors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic pushJob(input logic [31:0] x, input logic [31:0] y, input logic [15:0] c);
      int n = 0;
      jobX = x; jobY = y; jobZ = '0; jobControl = c; jobValid = 1'b1;
      #1;
      while (!jobReady && n < 400) begin
         @(negedge clk);
         n++;
      end
      checkEq("push_ready", 64'(jobReady), 1);
      @(posedge clk);
      @(negedge clk);
      jobValid = 1'b0;
   endtask

   task automatic popResult();
      resultReady = 1'b1;
      @(posedge clk);
      @(negedge clk);
      resultReady = 1'b0;
   endtask

   task automatic waitResult(input string tag, input int bound);
      int n = 0;
      while (!resultValid && n < bound) begin
         @(negedge clk);
         n++;
      end
      checkEq(tag, 64'(resultValid), 1);
   endtask

   initial begin
      int s0;
      int p0;
      int st0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkEq("rst_cordicRst", 64'(cordicRst), 1);
      checkEq("rst_jobCount", 64'(jobCount), 0);
      checkEq("rst_resultCount", 64'(resultCount), 0);
      checkEq("rst_resultValid", 64'(resultValid), 0);
      checkEq("rst_jobReady", 64'(jobReady), 0);
      checkEq("rst_startStop", 64'(controlRegisterInput[1:0]), 0);
      rst = 1'b1;
      #1;
      checkEq("rel_cordicRst_hold", 64'(cordicRst), 1);
      checkEq("rel_jobReady_hold", 64'(jobReady), 0);
      @(negedge clk);
      checkEq("rel_cordicRst_clear", 64'(cordicRst), 0);
      checkEq("rel_jobReady", 64'(jobReady), 1);

      // Single circular job
      s0 = startCount;
      pushJob(32'h4000_0000, 32'h0, 16'h1F2C);
      checkEq("single_idle_start", 64'(controlRegisterInput[0]), 0);
      checkEq("single_jobCount", 64'(jobCount), 1);
      @(negedge clk);
      checkEq("single_start", 64'(controlRegisterInput[0]), 1);
      checkEq("single_xInput", 64'(xInput), 64'h4000_0000);
      checkEq("single_ctrlIn", 64'(controlRegisterInput), 64'h1F2D);
      @(negedge clk);
      checkEq("single_start_drop", 64'(controlRegisterInput[0]), 0);
      waitResult("single_wait", 200);
      checkEq("single_flags", 64'(resultFlags), 64'h07C1_1F2C);
      checkEq("single_iter", 64'(resultFlags[26:22]), 31);
      checkEq("single_x", 64'(resultX), 64'h4000_001F);
      checkEq("single_z", 64'(resultZ), 64'h1F2C);
      checkEq("single_resultCount", 64'(resultCount), 1);
      checkEq("single_starts", 64'(startCount - s0), 1);
      popResult();
      checkEq("single_drained", 64'(resultCount), 0);

      // Five jobs into a 4-deep queue, results never popped
      pause = 1'b1;
      for (int i = 1; i <= 4; i++) pushJob(32'h100 * i, i, 16'h1F2C);
      checkEq("full_jobCount", 64'(jobCount), 4);
      checkEq("full_jobReady", 64'(jobReady), 0);
      pause = 1'b0;
      pushJob(32'h500, 32'd5, 16'h1F2C);
      repeat (300) @(negedge clk);
      checkEq("stall_resultCount", 64'(resultCount), 4);
      checkEq("stall_jobCount", 64'(jobCount), 0);
      checkEq("stall_head_x", 64'(resultX), 64'h11F);
      popResult();
      repeat (3) @(negedge clk);
      checkEq("stall_refill", 64'(resultCount), 4);
      for (int i = 2; i <= 5; i++) begin
         checkEq("order_x", 64'(resultX), 64'(32'h100 * i + 32'h1F));
         checkEq("order_y", 64'(resultY), 64'(i));
         popResult();
      end
      checkEq("order_empty", 64'(resultValid), 0);

      // Hyperbolic job with an out-of-range input
      s0 = startCount;
      pushJob(32'h1000_0000, 32'h2000_0000, 16'h1F20);
      waitResult("hyp_wait", 200);
      checkEq("hyp_flags", 64'(resultFlags), 64'h0003_1F20);
      checkEq("hyp_err", 64'(resultFlags[17]), 1);
      repeat (10) @(negedge clk);
      checkEq("hyp_starts", 64'(startCount - s0), 1);
      popResult();

      // Software abort while running
      begin
         int n = 0;
         pushJob(32'h4000_0000, 32'h0, 16'h1F2C);
         while (!(controlRegisterWriteEnable && !controlRegisterOutput[16]) && n < 50) begin
            @(negedge clk);
            n++;
         end
         checkEq("abort_accept", 64'(controlRegisterWriteEnable), 1);
      end
      repeat (3) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      checkEq("abort_stop_set", 64'(controlRegisterInput[1]), 1);
      waitResult("abort_wait", 200);
      checkEq("abort_iter_lt31", 64'(resultFlags[26:22] < 5'd31), 1);
      checkEq("abort_ready", 64'(resultFlags[16]), 1);
      checkEq("abort_stop_clear", 64'(controlRegisterInput[1]), 0);
      popResult();

      // Reset while a job is running
      pushJob(32'h4000_0000, 32'h0, 16'h1F2C);
      repeat (10) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checkEq("midrst_cordicRst", 64'(cordicRst), 1);
      checkEq("midrst_jobCount", 64'(jobCount), 0);
      checkEq("midrst_resultCount", 64'(resultCount), 0);
      checkEq("midrst_resultValid", 64'(resultValid), 0);
      checkEq("midrst_jobReady", 64'(jobReady), 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      checkEq("midrel_cordicRst", 64'(cordicRst), 1);
      checkEq("midrel_jobReady", 64'(jobReady), 0);
      @(negedge clk);
      checkEq("midrel_jobReady_up", 64'(jobReady), 1);
      repeat (50) @(negedge clk);
      checkEq("midrst_job_lost", 64'(resultCount), 0);

`ifdef CORDIC_JQ_TIMEOUT_EN
      // Controller that never reports Ready
      neverReady = 1'b1;
      p0 = rstPulses;
      st0 = stopCycles;
      pushJob(32'h4000_0000, 32'h0, 16'h1F2C);
      waitResult("to_wait", 100);
      checkEq("to_flags", 64'(resultFlags), 64'hFFFF_0000);
      checkEq("to_x", 64'(resultX), 0);
      checkEq("to_rst_pulse", 64'(rstPulses - p0), 1);
      checkEq("to_stop_seen", 64'(stopCycles > st0), 1);
      checkEq("to_stop_clear", 64'(controlRegisterInput[1]), 0);
      neverReady = 1'b0;
      popResult();
      @(negedge clk);
      checkEq("to_jobReady", 64'(jobReady), 1);
`else
      p0 = 0;
      st0 = 0;
`endif

      $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
      $finish;
   end
endmodule
